// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_I_WAIT = 2'd1,
        ARB_D_WAIT = 2'd2,
        ARB_D_DONE = 2'd3
    } arb_state_t;

    // Grant codes; declaration order is priority order (data before fetch miss).
    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_DATA  = 2'd1,
        GNT_FETCH = 2'd2
    } arb_grant_t;

    // Priority encoder over the two requesters.
    function automatic arb_grant_t pick_grant(input logic data_req, input logic fetch_req);
        if (data_req) begin
            return GNT_DATA;
        end
        if (fetch_req) begin
            return GNT_FETCH;
        end
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline F/M ports and unified memory port seen by the arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Fetch stage
    logic              if_req_f;
    logic [ADDR_W-1:0] if_addr_f;
    logic [DATA_W-1:0] if_rdata_f;
    logic              if_done_f;
    // Memory stage
    logic              dm_req_m;
    logic              dm_we_m;
    logic [ADDR_W-1:0] dm_addr_m;
    logic [DATA_W-1:0] dm_wdata_m;
    logic [DATA_W-1:0] dm_rdata_m;
    logic              dm_done_m;
    // Memory
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    // Hazard unit / status
    logic              mem_stall;
    logic              bus_err;

    // Arbiter side.
    modport master (
        input  if_req_f, if_addr_f,
        input  dm_req_m, dm_we_m, dm_addr_m, dm_wdata_m,
        input  mem_ready, mem_rdata,
        output if_rdata_f, if_done_f,
        output dm_rdata_m, dm_done_m,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output mem_stall, bus_err
    );

    // Pipeline and memory side.
    modport slave (
        output if_req_f, if_addr_f,
        output dm_req_m, dm_we_m, dm_addr_m, dm_wdata_m,
        output mem_ready, mem_rdata,
        input  if_rdata_f, if_done_f,
        input  dm_rdata_m, dm_done_m,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_stall, bus_err
    );

endinterface

// File: rtl/fetch_line_buffer.sv
// One-entry instruction buffer: avoids refetching while the pipeline is stalled.
module fetch_line_buffer #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              inval_i,
    input  logic              lookup_req_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic              hit_c,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    // Load has precedence; the arbiter never asserts load and invalidate together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            addr_q  <= load_addr_i;
            data_q  <= load_data_i;
        end else if (inval_i) begin
            valid_q <= 1'b0;
        end
    end

    // Combinational lookup against the held line.
    assign hit_c  = lookup_req_i & valid_q & (addr_q == lookup_addr_i);
    assign data_o = data_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between fetch (F) and memory (M) stages.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_port_arbiter_if.master  bus
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_t        state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic              dm_done_q,   dm_done_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic              if_done_q,   if_done_d;
    logic              bus_err_q,   bus_err_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;

    logic              hit;
    logic [DATA_W-1:0] buf_data;
    logic              buf_load;
    logic              buf_inval;
    logic              fetch_miss;
    logic              expired;
    arb_grant_t        gnt;

    fetch_line_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_i        (buf_load),
        .load_addr_i   (mem_addr_q),
        .load_data_i   (bus.mem_rdata),
        .inval_i       (buf_inval),
        .lookup_req_i  (bus.if_req_f),
        .lookup_addr_i (bus.if_addr_f),
        .hit_c         (hit),
        .data_o        (buf_data)
    );

    // A fetch whose done pulse is already registered must not be reissued.
    assign fetch_miss = bus.if_req_f & ~hit & ~if_done_q;
    assign expired    = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state, grant and completion logic.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        dm_rdata_d  = dm_rdata_q;
        dm_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_done_d   = 1'b0;
        bus_err_d   = bus_err_q;
        cnt_d       = cnt_q;
        buf_load    = 1'b0;
        buf_inval   = 1'b0;
        gnt         = GNT_NONE;

        case (state_q)
            ARB_IDLE: begin
                gnt = pick_grant(bus.dm_req_m, fetch_miss);
            end
            ARB_D_DONE: begin
                // Held dm_req_m is in its completion cycle here, so only fetch may win.
                state_d = ARB_IDLE;
                gnt     = pick_grant(1'b0, fetch_miss);
            end
            ARB_I_WAIT: begin
                if (bus.mem_ready) begin
                    mem_req_d  = 1'b0;
                    buf_load   = 1'b1;
                    if_rdata_d = bus.mem_rdata;
                    if_done_d  = 1'b1;
                    state_d    = ARB_IDLE;
                end else if (expired) begin
                    mem_req_d  = 1'b0;
                    bus_err_d  = 1'b1;
                    if_rdata_d = '0;
                    if_done_d  = 1'b1;
                    state_d    = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB_D_WAIT: begin
                if (bus.mem_ready) begin
                    mem_req_d  = 1'b0;
                    dm_rdata_d = bus.mem_rdata;
                    dm_done_d  = 1'b1;
                    state_d    = ARB_D_DONE;
                end else if (expired) begin
                    mem_req_d  = 1'b0;
                    bus_err_d  = 1'b1;
                    dm_rdata_d = '0;
                    dm_done_d  = 1'b1;
                    state_d    = ARB_D_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        case (gnt)
            GNT_DATA: begin
                mem_req_d   = 1'b1;
                mem_we_d    = bus.dm_we_m;
                mem_addr_d  = bus.dm_addr_m;
                mem_wdata_d = bus.dm_wdata_m;
                buf_inval   = bus.dm_we_m;
                cnt_d       = '0;
                state_d     = ARB_D_WAIT;
            end
            GNT_FETCH: begin
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = bus.if_addr_f;
                cnt_d      = '0;
                state_d    = ARB_I_WAIT;
            end
            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            dm_rdata_q  <= '0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_done_q   <= dm_done_d;
            if_rdata_q  <= if_rdata_d;
            if_done_q   <= if_done_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Fetch completion is a buffer hit or the registered pulse after a memory/timeout finish.
    assign bus.if_done_f  = if_done_q | hit;
    assign bus.if_rdata_f = if_done_q ? if_rdata_q : (hit ? buf_data : '0);

    assign bus.dm_done_m  = dm_done_q;
    assign bus.dm_rdata_m = dm_rdata_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.bus_err    = bus_err_q;

    // Stall term for the hazard unit.
    assign bus.mem_stall  = (bus.if_req_f & ~bus.if_done_f) | (bus.dm_req_m & ~bus.dm_done_m);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed cycle-vector bench for mem_port_arbiter (TIMEOUT = 4).
module tb_mem_port_arbiter;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fr;
        logic [31:0] fa;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic        rdy;
        logic [31:0] rd;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_ido;
        logic [31:0] e_ird;
        logic        e_ddo;
        logic [31:0] e_drd;
        logic        e_stall;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.if_req_f   = v.fr;
        bus.if_addr_f  = v.fa;
        bus.dm_req_m   = v.dr;
        bus.dm_we_m    = v.dw;
        bus.dm_addr_m  = v.da;
        bus.dm_wdata_m = v.dd;
        bus.mem_ready  = v.rdy;
        bus.mem_rdata  = v.rd;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d mem_req", i),   32'(bus.mem_req),   32'(v.e_mreq));
        chk($sformatf("v%0d if_done", i),   32'(bus.if_done_f), 32'(v.e_ido));
        chk($sformatf("v%0d dm_done", i),   32'(bus.dm_done_m), 32'(v.e_ddo));
        chk($sformatf("v%0d mem_stall", i), 32'(bus.mem_stall), 32'(v.e_stall));
        chk($sformatf("v%0d bus_err", i),   32'(bus.bus_err),   32'(v.e_err));
        if (v.e_mreq) begin
            chk($sformatf("v%0d mem_we", i),   32'(bus.mem_we), 32'(v.e_mwe));
            chk($sformatf("v%0d mem_addr", i), bus.mem_addr,    v.e_maddr);
            if (v.e_mwe) begin
                chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, v.e_mwdata);
            end
        end
        if (v.e_ido) begin
            chk($sformatf("v%0d if_rdata", i), bus.if_rdata_f, v.e_ird);
        end
        if (v.e_ddo) begin
            chk($sformatf("v%0d dm_rdata", i), bus.dm_rdata_m, v.e_drd);
        end
    endtask

    initial begin
        vec_t idle_v;
        total = 0;
        bad   = 0;
        idle_v = '{0,0,0,0,0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0};

        //            fr fa     dr dw da     dd     rdy rd          mreq we maddr  mwdata ido ird          ddo drd          stall err
        // Fetch miss 0x100, memory ready on the third request cycle.
        vecs.push_back('{1,32'h100,0,0,0,0,           0,0,           0,0,0,0,             0,0,           0,0,           1,0});
        vecs.push_back('{1,32'h100,0,0,0,0,           0,0,           1,0,32'h100,0,       0,0,           0,0,           1,0});
        vecs.push_back('{1,32'h100,0,0,0,0,           0,0,           1,0,32'h100,0,       0,0,           0,0,           1,0});
        vecs.push_back('{1,32'h100,0,0,0,0,           1,32'hAAAA0001,1,0,32'h100,0,       0,0,           0,0,           1,0});
        vecs.push_back('{1,32'h100,0,0,0,0,           0,0,           0,0,0,0,             1,32'hAAAA0001,0,0,           0,0});
        // Same fetch held: served from the buffer, no memory traffic.
        for (int k = 0; k < 5; k++) begin
            vecs.push_back('{1,32'h100,0,0,0,0,       0,0,           0,0,0,0,             1,32'hAAAA0001,0,0,           0,0});
        end
        // Load and fetch miss together: data first, fetch granted in D_DONE.
        vecs.push_back('{1,32'h104,1,0,32'h300,0,     0,0,           0,0,0,0,             0,0,           0,0,           1,0});
        vecs.push_back('{1,32'h104,1,0,32'h300,0,     1,32'hD0D00001,1,0,32'h300,0,       0,0,           0,0,           1,0});
        vecs.push_back('{1,32'h104,1,0,32'h300,0,     0,0,           0,0,0,0,             0,0,           1,32'hD0D00001,1,0});
        vecs.push_back('{1,32'h104,0,0,0,0,           1,32'h11110104,1,0,32'h104,0,       0,0,           0,0,           1,0});
        vecs.push_back('{1,32'h104,0,0,0,0,           0,0,           0,0,0,0,             1,32'h11110104,0,0,           0,0});
        // Store while fetch hits: hit completes in grant cycle, buffer invalid afterwards.
        vecs.push_back('{1,32'h104,1,1,32'h200,32'h5555,0,0,         0,0,0,0,             1,32'h11110104,0,0,           1,0});
        vecs.push_back('{0,0,      1,1,32'h200,32'h5555,1,0,         1,1,32'h200,32'h5555,0,0,           0,0,           1,0});
        vecs.push_back('{0,0,      1,1,32'h200,32'h5555,0,0,         0,0,0,0,             0,0,           1,0,           0,0});
        vecs.push_back('{1,32'h104,0,0,0,0,           0,0,           0,0,0,0,             0,0,           0,0,           1,0});
        vecs.push_back('{1,32'h104,0,0,0,0,           1,32'h22220104,1,0,32'h104,0,       0,0,           0,0,           1,0});
        vecs.push_back('{1,32'h104,0,0,0,0,           0,0,           0,0,0,0,             1,32'h22220104,0,0,           0,0});
        // Load that never gets mem_ready: 4 request cycles, done with 0, sticky bus_err.
        vecs.push_back('{0,0,      1,0,32'h400,0,     0,0,           0,0,0,0,             0,0,           0,0,           1,0});
        for (int k = 0; k < 4; k++) begin
            vecs.push_back('{0,0,  1,0,32'h400,0,     0,32'hFFFFFFFF,1,0,32'h400,0,       0,0,           0,0,           1,0});
        end
        vecs.push_back('{0,0,      1,0,32'h400,0,     0,0,           0,0,0,0,             0,0,           1,0,           0,1});
        vecs.push_back('{0,0,      0,0,0,0,           0,0,           0,0,0,0,             0,0,           0,0,           0,1});
        // Fetch requester drops mid-wait: transaction and done pulse still happen.
        vecs.push_back('{1,32'h108,0,0,0,0,           0,0,           0,0,0,0,             0,0,           0,0,           1,1});
        vecs.push_back('{0,0,      0,0,0,0,           0,0,           1,0,32'h108,0,       0,0,           0,0,           0,1});
        vecs.push_back('{0,0,      0,0,0,0,           1,32'h33330108,1,0,32'h108,0,       0,0,           0,0,           0,1});
        vecs.push_back('{0,0,      0,0,0,0,           0,0,           0,0,0,0,             1,32'h33330108,0,0,           0,1});
        vecs.push_back('{1,32'h108,0,0,0,0,           0,0,           0,0,0,0,             1,32'h33330108,0,0,           0,1});

        // Reset values.
        drive(idle_v);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst mem_req",   32'(bus.mem_req),   32'd0);
        chk("rst mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst mem_addr",  bus.mem_addr,       32'd0);
        chk("rst mem_wdata", bus.mem_wdata,      32'd0);
        chk("rst dm_done",   32'(bus.dm_done_m), 32'd0);
        chk("rst dm_rdata",  bus.dm_rdata_m,     32'd0);
        chk("rst if_done",   32'(bus.if_done_f), 32'd0);
        chk("rst bus_err",   32'(bus.bus_err),   32'd0);
        chk("rst mem_stall", 32'(bus.mem_stall), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: drive after the edge, check on the falling edge.
        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            check_vec(i, vecs[i]);
            @(posedge clk);
            #1;
        end

        // Reset during D_WAIT clears everything asynchronously.
        drive(idle_v);
        bus.dm_req_m  = 1'b1;
        bus.dm_addr_m = 32'h500;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre-rst mem_req",  32'(bus.mem_req), 32'd1);
        chk("pre-rst mem_addr", bus.mem_addr,     32'h500);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async rst mem_req",  32'(bus.mem_req),   32'd0);
        chk("async rst mem_addr", bus.mem_addr,       32'd0);
        chk("async rst bus_err",  32'(bus.bus_err),   32'd0);
        chk("async rst dm_done",  32'(bus.dm_done_m), 32'd0);
        drive(idle_v);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        // Fresh fetch of a previously buffered address must miss, then complete with zero wait.
        bus.if_req_f  = 1'b1;
        bus.if_addr_f = 32'h108;
        @(negedge clk);
        chk("post-rst if_done (buf cleared)", 32'(bus.if_done_f), 32'd0);
        chk("post-rst mem_stall",             32'(bus.mem_stall), 32'd1);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h44440108;
        @(negedge clk);
        chk("post-rst mem_req",  32'(bus.mem_req), 32'd1);
        chk("post-rst mem_addr", bus.mem_addr,     32'h108);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        @(negedge clk);
        chk("post-rst if_done",  32'(bus.if_done_f), 32'd1);
        chk("post-rst if_rdata", bus.if_rdata_f,     32'h44440108);
        chk("post-rst mem_req",  32'(bus.mem_req),   32'd0);
        chk("post-rst bus_err",  32'(bus.bus_err),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing a single-ported unified memory between the pipeline's fetch stage (F) and memory stage (M). It sits beside the hazard unit and drives a `mem_stall` term that the hazard unit ORs into `stall_f`/`stall_d`/`flush_x`. A one-entry fetch buffer prevents refetching while the pipeline is stalled for unrelated hazards. A timeout counter guards against a hung memory.

## Interface
- `ADDR_W`, 32: address width, byte addresses.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 255: maximum number of `mem_req` cycles before the transaction is aborted; must be ≥ 1.

Ports:
- `clk`  in  1  — sole clock.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `if_req_f`  in  1  — fetch request; held until `if_done_f`.
- `if_addr_f`  in  ADDR_W  — fetch address.
- `if_rdata_f`  out  DATA_W  — instruction; valid while `if_done_f`.
- `if_done_f`  out  1  — fetch complete, for 1 cycle (either buffer hit or memory).
- `dm_req_m`  in  1  — data request; held until `dm_done_m`.
- `dm_we_m`  in  1  — 1 = store, 0 = load.
- `dm_addr_m`  in  ADDR_W  — data address.
- `dm_wdata_m`  in  DATA_W  — store data.
- `dm_rdata_m`  out  DATA_W  — load data; valid while `dm_done_m`.
- `dm_done_m`  out  1  — data access complete; 1-cycle pulse.
- `mem_req`, `mem_we`  out  1  — memory strobe and write enable.
- `mem_addr`  out  ADDR_W  — memory address.
- `mem_wdata`  out  DATA_W  — memory write data.
- `mem_ready`  in  1  — memory completion; meaningful only while `mem_req` = 1.
- `mem_rdata`  in  DATA_W  — memory read data; valid with `mem_ready`.
- `mem_stall`  out  1  — `(if_req_f & ~if_done_f) | (dm_req_m & ~dm_done_m)`; combinational.
- `bus_err`  out  1  — sticky; set on a timeout; cleared only by reset.

## Operation
- FSM states: `IDLE`, `I_WAIT`, `D_WAIT`, `D_DONE`.
- Fetch hit:
  - `hit = if_req_f & buf_valid & (buf_addr == if_addr_f)`.
  - A hit asserts `if_done_f` combinationally, with `if_rdata_f = buf_data`, in any state.
  - A hit never touches memory.
- `IDLE` and `D_DONE` grant. Priority is data, then fetch miss.
- `D_DONE` does not grant data. This prevents reissuing a held `dm_req_m` in its completion cycle.
- Grant of data:
  - Register `mem_addr`/`mem_we`/`mem_wdata` from the M port and set `mem_req`.
  - Go to `D_WAIT`.
  - If `dm_we_m` = 1, clear `buf_valid` at the same edge.
- Grant of fetch miss: register the F address, set `mem_req` (`mem_we` = 0), and go to `I_WAIT`.
- `I_WAIT` on `mem_ready`:
  - Drop `mem_req`.
  - Load `buf_addr`/`buf_data`/`buf_valid` = 1.
  - Pulse `if_done_f` next cycle (that cycle is also a buffer hit).
  - Go to `IDLE`.
- `D_WAIT` on `mem_ready`:
  - Drop `mem_req`.
  - Register `dm_rdata_m`, pulse `dm_done_m`.
  - Go to `D_DONE`.
- `D_DONE` with no grant goes to `IDLE`.
- Timeout counter:
  - Cleared on every grant.
  - Increments each cycle in `I_WAIT`/`D_WAIT`.
  - When it reaches `TIMEOUT` without `mem_ready`: drop `mem_req`, set `bus_err`, and pulse the pending port's done with rdata = 0.
  - `buf_valid` is not set on a fetch timeout.
  - Next state is `IDLE` for a fetch timeout and `D_DONE` for a data timeout.
- `mem_req` stays constant (address, data, we) from grant until `mem_ready` or timeout.
- A requester dropping its request while in `*_WAIT` does not abort the transaction. The done pulse still occurs.

## Timing
- Reset values:
  - state = `IDLE`.
  - `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata` = 0.
  - `dm_rdata_m` = 0, `dm_done_m` = 0.
  - `buf_valid` = 0, `buf_addr`, `buf_data` = 0.
  - `bus_err` = 0; counter = 0.
- Miss latency:
  - Request sampled at edge N; `mem_req` high in cycle N+1.
  - `mem_ready` sampled at edge M ≥ N+1; done in cycle M+1.
  - A zero-wait memory gives done 2 cycles after the request.
- Hit latency: 0 cycles.
- Back-to-back data accesses: minimum 3 cycles apart (grant, wait, `D_DONE`).
- A fetch may be granted in `D_DONE`.
- Simultaneous data and fetch-miss in `IDLE`: data wins; the fetch waits.
- A store that invalidates the buffer during a pending fetch hit: the hit in the grant cycle still completes; the buffer is invalid from the next cycle.
- Reset asserted mid-transaction: all state is cleared immediately. The memory must tolerate `mem_req` dropping.

## Structure
- Package `mem_arb_pkg`:
  - State enum `arb_state_t`.
  - Default `TIMEOUT`.
  - Priority constants.
- Sub-module `fetch_line_buffer`:
  - Holds address, data and valid.
  - Provides load, invalidate and the combinational hit compare.
- FSM, counter and memory registers stay at top level.

## Test plan
- Single fetch miss, memory ready after 3 cycles, addr 0x100 → `mem_req` 3 cycles, `if_done_f` 1 cycle later with data; `mem_stall` high until done.
- Same fetch held 5 further cycles → `if_done_f` each cycle from the buffer, `mem_req` stays 0.
- Load and fetch miss in the same `IDLE` cycle → data granted first, then `D_DONE`, then fetch granted in `D_DONE`; no duplicate load issued.
- Store to 0x200 after buffer holds 0x100 → `buf_valid` cleared; next fetch of 0x100 goes to memory.
- `mem_ready` never asserted, `TIMEOUT` = 4 → `mem_req` high 4 cycles, done pulse with rdata 0, `bus_err` = 1 and stays set.
- `reset_n` low during `D_WAIT` → all outputs return to reset values asynchronously; a fresh request after release completes normally.
